pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline (fetch, decode, execute, memory, writeback).
- Detects load-use hazards between decode and execute, and freezes the front end while a multi-cycle execute op (divider/FPU) is busy.
- Squashes wrong-path instructions on an execute-stage PC correction, and drains the pipeline on EBREAK into a halted state.
- Issues abort and timeout control to the multi-cycle units and keeps stall/flush performance counters.

Parameters:
- MC_TIMEOUT, 64: maximum consecutive busy cycles before the watchdog aborts a multi-cycle op (minimum 2).
- DRAIN_CYCLES, 2: cycles spent in DRAIN so older instructions retire through memory and writeback.

Ports:
- clk_i  in  1  system clock; single clock domain.
- reset_i  in  1  asynchronous, active-low reset.
- D_rs1Id_i, D_rs2Id_i, D_rs3Id_i  in  6 each  source register ids of the instruction in decode (ids 32..63 are FP registers).
- D_rs1Used_i, D_rs2Used_i, D_rs3Used_i  in  1 each  the corresponding source is actually read.
- DE_isLoad_i  in  1  execute-stage instruction is a load.
- DE_wbEnable_i  in  1  execute-stage instruction writes a register.
- DE_rdId_i  in  6  execute-stage destination id.
- aluBusy_i  in  1  multi-cycle unit busy (combinational from execute).
- EM_correctPC_i  in  1  the instruction now in memory mispredicted; fetch is being redirected.
- HALT_i  in  1  EBREAK present in execute.
- F_stall_o, D_stall_o, E_stall_o  out  1 each  hold the PC, FD and DE registers respectively.
- D_flush_o, E_flush_o, M_flush_o  out  1 each  force a NOP into the FD, DE and EM registers.
- dataHazard_o  out  1  load-use hazard detected this cycle.
- mcAbort_o  out  1  single-cycle pulse that cancels the in-flight multi-cycle op.
- mcTimeout_o  out  1  sticky watchdog error flag.
- halted_o  out  1  core halted.
- stallCycles_o  out  32  count of cycles with F_stall_o asserted.
- flushEvents_o  out  32  count of PC corrections.

Behaviour:
- Reset (reset_i low, asynchronous):
  - state = RUN; all stall/flush outputs 0; mcAbort_o 0; mcTimeout_o 0; halted_o 0; both counters 0; watchdog counter 0; drain counter 0.
- State is registered; the stall/flush/abort outputs are combinational from state plus inputs, so a stall takes effect in the same cycle as its cause.
- Hazard term: dataHazard_o = DE_isLoad_i & DE_wbEnable_i & (DE_rdId_i != 0) & any(DrsNUsed & DrsNId == DE_rdId_i).
  - Id 0 never hazards; id 32 (f0) does.
- States: RUN, MCWAIT, DRAIN, HALTED.
- RUN, in priority order:
  1. EM_correctPC_i: D_flush_o = E_flush_o = M_flush_o = 1; no stalls; mcAbort_o = aluBusy_i; flushEvents_o += 1; stay in RUN. Overrides HALT_i, busy and hazard.
  2. HALT_i: F/D/E stall = 1; M_flush_o = 1; drain counter = DRAIN_CYCLES; go to DRAIN.
  3. aluBusy_i: F/D/E stall = 1; M_flush_o = 1; watchdog = 1; go to MCWAIT.
  4. dataHazard_o: F/D stall = 1; E_flush_o = 1 (bubble into execute); stay in RUN.
  5. Otherwise: all outputs 0.
- MCWAIT:
  - EM_correctPC_i: same action as RUN case 1 (including mcAbort_o = 1); go to RUN.
  - Otherwise, if aluBusy_i == 0: outputs as RUN cases 4/5 (hazard check applies); go to RUN. The result is captured in the same cycle busy drops.
  - Otherwise, if watchdog == MC_TIMEOUT-1: mcAbort_o = 1; mcTimeout_o set (sticky until reset); F/D/E stall held this cycle; go to RUN.
  - Otherwise: F/D/E stall = 1; M_flush_o = 1; watchdog += 1.
- DRAIN:
  - F/D/E stall = 1 and M_flush_o = 1 every cycle.
  - EM_correctPC_i (the EBREAK was wrong-path): RUN case 1 action; go to RUN.
  - Otherwise decrement the drain counter; at 0 go to HALTED.
- HALTED: F/D/E stall = 1; M_flush_o = 1; halted_o = 1; all inputs ignored; exit only via reset.
- Counters: 32-bit, wrap modulo 2^32, no saturation.
  - stallCycles_o counts every cycle with F_stall_o = 1, including HALTED.
- mcAbort_o is never asserted for two consecutive cycles.

Decomposition:
- Shared package (hazard_pkg): state encoding (2-bit: RUN = 0, MCWAIT = 1, DRAIN = 2, HALTED = 3) and a REG_X0 = 6'd0 constant.
- One sub-module, hazard_detect: purely combinational load-use comparator producing dataHazard_o.
- FSM, watchdog and counters stay in pipeline_hazard_ctrl.

Test Plan:
- Load-use: DE load with rd = 5, D rs2 = 5 used → one cycle of F/D stall + E_flush_o + dataHazard_o; next cycle (DE no longer a load) everything 0; stallCycles_o = 1. Repeat with rd = 0 → no hazard.
- Divide: aluBusy_i high 33 cycles → F/D/E stall and M_flush_o for exactly 33 cycles; all clear on the cycle busy drops; mcTimeout_o stays 0.
- Watchdog: MC_TIMEOUT = 8 with aluBusy_i stuck high → mcAbort_o pulses in cycle 8; mcTimeout_o = 1 and stays set; state returns to RUN.
- Correction precedence: EM_correctPC_i, HALT_i, aluBusy_i and a hazard all in one RUN cycle → D/E/M flush = 1, mcAbort_o = 1, no stalls, flushEvents_o = 1, state stays RUN.
- Halt: HALT_i pulse → 2 DRAIN cycles then halted_o = 1 permanently. A second run with EM_correctPC_i during DRAIN returns to RUN with halted_o = 0.
- Reset mid-MCWAIT: assert reset_i low asynchronously between clock edges → all outputs 0 immediately; state RUN after release.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
// Holds the FSM encoding and the hard-wired zero register id.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MCWAIT = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam logic [5:0] REG_X0 = 6'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator between decode sources and the execute-stage load destination.
// Purely combinational; no latency, no backpressure.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [5:0] rs1_id_i,
  input  logic [5:0] rs2_id_i,
  input  logic [5:0] rs3_id_i,
  input  logic       rs1_used_i,
  input  logic       rs2_used_i,
  input  logic       rs3_used_i,
  input  logic       de_is_load_i,
  input  logic       de_wb_enable_i,
  input  logic [5:0] de_rd_id_i,
  output logic       hazard_o
);

  logic src_hit;

  always_comb begin
    src_hit = (rs1_used_i && (rs1_id_i == de_rd_id_i)) ||
              (rs2_used_i && (rs2_id_i == de_rd_id_i)) ||
              (rs3_used_i && (rs3_id_i == de_rd_id_i));
    // x0 is hard-wired; FP register 0 (id 32) is a real register and may hazard.
    hazard_o = de_is_load_i && de_wb_enable_i && (de_rd_id_i != REG_X0) && src_hit;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, multi-cycle wait, redirect, halt drain.
// Control outputs are combinational from registered state plus inputs (zero latency); counters lag one cycle.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MC_TIMEOUT   = 64,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [5:0]  D_rs1Id_i,
  input  logic [5:0]  D_rs2Id_i,
  input  logic [5:0]  D_rs3Id_i,
  input  logic        D_rs1Used_i,
  input  logic        D_rs2Used_i,
  input  logic        D_rs3Used_i,
  input  logic        DE_isLoad_i,
  input  logic        DE_wbEnable_i,
  input  logic [5:0]  DE_rdId_i,
  input  logic        aluBusy_i,
  input  logic        EM_correctPC_i,
  input  logic        HALT_i,
  output logic        F_stall_o,
  output logic        D_stall_o,
  output logic        E_stall_o,
  output logic        D_flush_o,
  output logic        E_flush_o,
  output logic        M_flush_o,
  output logic        dataHazard_o,
  output logic        mcAbort_o,
  output logic        mcTimeout_o,
  output logic        halted_o,
  output logic [31:0] stallCycles_o,
  output logic [31:0] flushEvents_o
);

  localparam int WD_W = $clog2(MC_TIMEOUT);
  localparam int DR_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_TIMEOUT - 1);
  localparam logic [DR_W-1:0] DR_INIT = DR_W'(DRAIN_CYCLES);

  state_e            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [DR_W-1:0]   drain_q, drain_d;
  logic              timeout_q, timeout_d;
  logic              abort_prev_q, abort_prev_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;
  logic [31:0]       flush_cnt_q, flush_cnt_d;

  logic hazard;
  logic f_stall, d_stall, e_stall, d_flush, e_flush, m_flush;
  logic abort_raw, abort, halted, pc_fix;

  hazard_detect u_hazard_detect (
    .rs1_id_i       (D_rs1Id_i),
    .rs2_id_i       (D_rs2Id_i),
    .rs3_id_i       (D_rs3Id_i),
    .rs1_used_i     (D_rs1Used_i),
    .rs2_used_i     (D_rs2Used_i),
    .rs3_used_i     (D_rs3Used_i),
    .de_is_load_i   (DE_isLoad_i),
    .de_wb_enable_i (DE_wbEnable_i),
    .de_rd_id_i     (DE_rdId_i),
    .hazard_o       (hazard)
  );

  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    drain_d   = drain_q;
    timeout_d = timeout_q;
    f_stall   = 1'b0;
    d_stall   = 1'b0;
    e_stall   = 1'b0;
    d_flush   = 1'b0;
    e_flush   = 1'b0;
    m_flush   = 1'b0;
    abort_raw = 1'b0;
    halted    = 1'b0;
    pc_fix    = 1'b0;

    // A redirect outranks everything except the terminal halted state.
    if (EM_correctPC_i && (state_q != ST_HALTED)) begin
      d_flush   = 1'b1;
      e_flush   = 1'b1;
      m_flush   = 1'b1;
      pc_fix    = 1'b1;
      abort_raw = (state_q == ST_MCWAIT) ? 1'b1 : aluBusy_i;
      state_d   = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (HALT_i) begin
            {f_stall, d_stall, e_stall, m_flush} = 4'b1111;
            drain_d = DR_INIT;
            state_d = ST_DRAIN;
          end else if (aluBusy_i) begin
            {f_stall, d_stall, e_stall, m_flush} = 4'b1111;
            wd_d    = WD_W'(1);
            state_d = ST_MCWAIT;
          end else if (hazard) begin
            {f_stall, d_stall, e_flush} = 3'b111;
          end
        end
        ST_MCWAIT: begin
          if (!aluBusy_i) begin
            state_d = ST_RUN;
            if (hazard) begin
              {f_stall, d_stall, e_flush} = 3'b111;
            end
          end else if (wd_q == WD_LAST) begin
            {f_stall, d_stall, e_stall} = 3'b111;
            abort_raw = 1'b1;
            timeout_d = 1'b1;
            state_d   = ST_RUN;
          end else begin
            {f_stall, d_stall, e_stall, m_flush} = 4'b1111;
            wd_d = wd_q + WD_W'(1);
          end
        end
        ST_DRAIN: begin
          {f_stall, d_stall, e_stall, m_flush} = 4'b1111;
          drain_d = drain_q - DR_W'(1);
          if (drain_q == DR_W'(1)) begin
            state_d = ST_HALTED;
          end
        end
        default: begin
          {f_stall, d_stall, e_stall, m_flush} = 4'b1111;
          halted = 1'b1;
        end
      endcase
    end

    // Back-to-back abort requests collapse to a single pulse.
    abort        = abort_raw && !abort_prev_q;
    abort_prev_d = abort;
    stall_cnt_d  = stall_cnt_q + {31'd0, f_stall};
    flush_cnt_d  = flush_cnt_q + {31'd0, pc_fix};
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= ST_RUN;
      wd_q         <= '0;
      drain_q      <= '0;
      timeout_q    <= 1'b0;
      abort_prev_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wd_q         <= wd_d;
      drain_q      <= drain_d;
      timeout_q    <= timeout_d;
      abort_prev_q <= abort_prev_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  // Gating with reset keeps the combinational outputs quiet while reset is held.
  assign F_stall_o     = reset_i && f_stall;
  assign D_stall_o     = reset_i && d_stall;
  assign E_stall_o     = reset_i && e_stall;
  assign D_flush_o     = reset_i && d_flush;
  assign E_flush_o     = reset_i && e_flush;
  assign M_flush_o     = reset_i && m_flush;
  assign dataHazard_o  = reset_i && hazard;
  assign mcAbort_o     = reset_i && abort;
  assign halted_o      = reset_i && halted;
  assign mcTimeout_o   = timeout_q;
  assign stallCycles_o = stall_cnt_q;
  assign flushEvents_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes model-predicted outputs, a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  localparam int T  = 40;
  localparam int DC = 2;

  localparam int M_RUN = 0, M_WAIT = 1, M_DRAIN = 2, M_HALT = 3;

  typedef struct packed {
    logic fs, ds, es, df, ef, mf, hz, ab, to, hl;
    logic [31:0] sc, fe;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic [5:0] rs1, rs2, rs3, rd;
  logic u1, u2, u3, ld, wb, busy, cpc, halt;

  logic F_stall_o, D_stall_o, E_stall_o, D_flush_o, E_flush_o, M_flush_o;
  logic dataHazard_o, mcAbort_o, mcTimeout_o, halted_o;
  logic [31:0] stallCycles_o, flushEvents_o;

  pipeline_hazard_ctrl #(.MC_TIMEOUT(T), .DRAIN_CYCLES(DC)) dut (
    .clk_i          (clk),
    .reset_i        (rst_n),
    .D_rs1Id_i      (rs1),
    .D_rs2Id_i      (rs2),
    .D_rs3Id_i      (rs3),
    .D_rs1Used_i    (u1),
    .D_rs2Used_i    (u2),
    .D_rs3Used_i    (u3),
    .DE_isLoad_i    (ld),
    .DE_wbEnable_i  (wb),
    .DE_rdId_i      (rd),
    .aluBusy_i      (busy),
    .EM_correctPC_i (cpc),
    .HALT_i         (halt),
    .F_stall_o      (F_stall_o),
    .D_stall_o      (D_stall_o),
    .E_stall_o      (E_stall_o),
    .D_flush_o      (D_flush_o),
    .E_flush_o      (E_flush_o),
    .M_flush_o      (M_flush_o),
    .dataHazard_o   (dataHazard_o),
    .mcAbort_o      (mcAbort_o),
    .mcTimeout_o    (mcTimeout_o),
    .halted_o       (halted_o),
    .stallCycles_o  (stallCycles_o),
    .flushEvents_o  (flushEvents_o)
  );

  exp_t   sb_q[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc    = 0;
  string  phase  = "init";
  logic [5:0] pool [5] = '{6'd0, 6'd1, 6'd5, 6'd32, 6'd33};

  // Reference model: pipeline condition tracked as a mode, busy-cycle age and drain countdown.
  int          m_mode, m_age, m_drain;
  bit          m_to, m_prev_ab;
  logic [31:0] m_sc, m_fe;

  function automatic exp_t got_now();
    return {F_stall_o, D_stall_o, E_stall_o, D_flush_o, E_flush_o, M_flush_o,
            dataHazard_o, mcAbort_o, mcTimeout_o, halted_o, stallCycles_o, flushEvents_o};
  endfunction

  task automatic model_reset();
    m_mode = M_RUN; m_age = 0; m_drain = 0;
    m_to = 0; m_prev_ab = 0; m_sc = 0; m_fe = 0;
  endtask

  task automatic model_step(output exp_t e);
    bit hz, raw;
    e   = '0;
    raw = 0;
    hz  = ld && wb && (rd != 6'd0) &&
          ((u1 && rs1 == rd) || (u2 && rs2 == rd) || (u3 && rs3 == rd));
    e.hz = hz;
    e.to = m_to;
    e.sc = m_sc;
    e.fe = m_fe;
    e.hl = (m_mode == M_HALT);
    if (m_mode == M_HALT) begin
      {e.fs, e.ds, e.es, e.mf} = 4'b1111;
    end else if (cpc) begin
      {e.df, e.ef, e.mf} = 3'b111;
      raw    = busy || (m_mode == M_WAIT);
      m_fe   = m_fe + 1;
      m_mode = M_RUN;
    end else if (m_mode == M_DRAIN) begin
      {e.fs, e.ds, e.es, e.mf} = 4'b1111;
      m_drain = m_drain - 1;
      if (m_drain == 0) m_mode = M_HALT;
    end else if (m_mode == M_WAIT && busy && m_age == T - 1) begin
      {e.fs, e.ds, e.es} = 3'b111;
      raw    = 1;
      m_to   = 1;
      m_mode = M_RUN;
    end else if (m_mode == M_WAIT && busy) begin
      {e.fs, e.ds, e.es, e.mf} = 4'b1111;
      m_age = m_age + 1;
    end else if (m_mode == M_RUN && halt) begin
      {e.fs, e.ds, e.es, e.mf} = 4'b1111;
      m_drain = DC;
      m_mode  = M_DRAIN;
    end else if (m_mode == M_RUN && busy) begin
      {e.fs, e.ds, e.es, e.mf} = 4'b1111;
      m_age  = 1;
      m_mode = M_WAIT;
    end else begin
      m_mode = M_RUN;
      if (hz) {e.fs, e.ds, e.ef} = 3'b111;
    end
    e.ab      = raw && !m_prev_ab;
    m_prev_ab = e.ab;
    if (e.fs) m_sc = m_sc + 1;
  endtask

  task automatic clear_in();
    rs1 = 0; rs2 = 0; rs3 = 0; rd = 0;
    u1 = 0; u2 = 0; u3 = 0; ld = 0; wb = 0;
    busy = 0; cpc = 0; halt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic push();
    exp_t e;
    model_step(e);
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick(); push();
    end
  endtask

  task automatic busy_for(input int n);
    for (int i = 0; i < n; i++) begin
      tick(); busy = 1; push();
    end
  endtask

  // Asserts reset between edges with inputs left as they are, checks outputs clear at once.
  task automatic reset_dut();
    exp_t g;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    g = got_now();
    checks++;
    if (g !== '0) begin
      errors++;
      $display("FAIL async_reset phase=%s got=%h exp=0", phase, g);
    end
    clear_in();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e, g;
    if (rst_n && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = got_now();
      checks++;
      cyc++;
      if (g !== e) begin
        errors++;
        $display("FAIL outputs phase=%s cyc=%0d got=%h exp=%h", phase, cyc, g, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout phase=%s", phase);
    $fatal(1, "bench time limit");
  end

  initial begin
    int busy_left;
    clear_in();
    model_reset();

    phase = "reset"; reset_dut(); idle(2);

    phase = "load_use";
    tick(); ld = 1; wb = 1; rd = 5; rs2 = 5; u2 = 1; push();
    idle(2);
    tick(); ld = 1; wb = 1; rd = 0; rs1 = 0; u1 = 1; push();
    tick(); ld = 1; wb = 1; rd = 32; rs3 = 32; u3 = 1; push();
    tick(); ld = 1; wb = 0; rd = 7; rs1 = 7; u1 = 1; push();
    tick(); ld = 1; wb = 1; rd = 7; rs1 = 7; u1 = 0; push();
    idle(1);

    phase = "divide"; reset_dut(); busy_for(33); idle(3);

    phase = "watchdog"; reset_dut(); busy_for(T + 2); idle(3);

    phase = "precedence"; reset_dut();
    tick(); ld = 1; wb = 1; rd = 5; rs2 = 5; u2 = 1; busy = 1; cpc = 1; halt = 1; push();
    tick(); busy = 1; cpc = 1; push();
    idle(2);

    phase = "halt"; reset_dut();
    tick(); halt = 1; push();
    idle(2);
    tick(); cpc = 1; busy = 1; ld = 1; wb = 1; rd = 3; rs1 = 3; u1 = 1; push();
    idle(2);

    phase = "halt_cancel"; reset_dut();
    tick(); halt = 1; push();
    idle(1);
    tick(); cpc = 1; push();
    idle(3);

    phase = "reset_mcwait"; reset_dut();
    busy_for(5);
    tick(); busy = 1; ld = 1; wb = 1; rd = 5; rs1 = 5; u1 = 1; push();
    @(negedge clk); #1; busy = 1; ld = 1; wb = 1; rd = 5; rs1 = 5; u1 = 1;
    reset_dut();
    idle(3);

    phase = "random";
    for (int seg = 0; seg < 8; seg++) begin
      reset_dut();
      busy_left = 0;
      for (int i = 0; i < 150; i++) begin
        tick();
        rs1 = pool[$urandom_range(0, 4)];
        rs2 = pool[$urandom_range(0, 4)];
        rs3 = pool[$urandom_range(0, 4)];
        rd  = pool[$urandom_range(0, 4)];
        u1  = $urandom_range(0, 1) == 1;
        u2  = $urandom_range(0, 1) == 1;
        u3  = $urandom_range(0, 1) == 1;
        ld  = $urandom_range(0, 1) == 1;
        wb  = $urandom_range(0, 3) != 0;
        if (busy_left == 0 && $urandom_range(0, 9) == 0) busy_left = $urandom_range(1, T + 8);
        busy = busy_left > 0;
        if (busy_left > 0) busy_left--;
        cpc  = $urandom_range(0, 19) == 0;
        halt = $urandom_range(0, 79) == 0;
        push();
      end
    end

    phase = "drain";
    idle(1);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
